// File: rtl/param_display_pkg.sv
// Shared types for the tuner parameter readout: selector codes, selector button
// states, glyph set, snapshot record and the edit-state predicate.
package param_display_pkg;

  localparam logic [2:0] SEL_GAIN        = 3'd0;
  localparam logic [2:0] SEL_LIVE        = 3'd1;
  localparam logic [2:0] SEL_COLOR       = 3'd2;
  localparam logic [2:0] SEL_COLOR_SCALE = 3'd3;
  localparam logic [2:0] SEL_MUSIC_SCALE = 3'd4;

  // Selector FSM state codes that mean "the user is editing/scrolling".
  localparam logic [3:0] BTN_NEXT_FUNCTION   = 4'b0111;
  localparam logic [3:0] BTN_SCROLL_PRESSED  = 4'b1001;
  localparam logic [3:0] BTN_SCROLL_FUNCTION = 4'b1010;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [4:0] {
    GL_0, GL_1, GL_2, GL_3, GL_4, GL_5, GL_6, GL_7, GL_8, GL_9,
    GL_A, GL_C, GL_E, GL_F, GL_G, GL_I, GL_L, GL_N, GL_O, GL_R,
    GL_T, GL_U, GL_H, GL_DASH, GL_BLANK
  } glyph_t;

  typedef struct packed {
    logic [2:0] selector_val;
    logic [3:0] button_state;
    logic [1:0] mag_scale;
    logic       live;
    logic       color;
    logic [2:0] scale_color;
    logic [1:0] scale_choice;
  } snap_t;

  function automatic logic is_edit_state(input logic [3:0] state);
    return (state == BTN_NEXT_FUNCTION) ||
           (state == BTN_SCROLL_PRESSED) ||
           (state == BTN_SCROLL_FUNCTION);
  endfunction

  // Numeric glyphs occupy enum codes 0..9, so a digit maps straight across.
  function automatic glyph_t digit_glyph(input logic [3:0] n);
    return glyph_t'({1'b0, n});
  endfunction

endpackage

// File: rtl/param_display_if.sv
// Settings bundle from the parameter selector plus the multiplexed display drive.
interface param_display_if;
  logic [2:0] selector_val;
  logic [3:0] button_state;
  logic [1:0] mag_scale;
  logic       live;
  logic       color;
  logic [2:0] scale_color;
  logic [1:0] scale_choice;
  logic [7:0] an_out;
  logic [6:0] cat_out;

  modport master (
    output selector_val, button_state, mag_scale, live, color, scale_color, scale_choice,
    input  an_out, cat_out
  );

  modport slave (
    input  selector_val, button_state, mag_scale, live, color, scale_color, scale_choice,
    output an_out, cat_out
  );
endinterface

// File: rtl/param_display_seg_glyph.sv
// Glyph code to active-low seven-segment pattern {g,f,e,d,c,b,a}.
module param_display_seg_glyph
  import param_display_pkg::*;
(
  input  glyph_t     glyph,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (glyph)
      GL_0:     seg = 7'b1000000;
      GL_1:     seg = 7'b1111001;
      GL_2:     seg = 7'b0100100;
      GL_3:     seg = 7'b0110000;
      GL_4:     seg = 7'b0011001;
      GL_5:     seg = 7'b0010010;
      GL_6:     seg = 7'b0000010;
      GL_7:     seg = 7'b1111000;
      GL_8:     seg = 7'b0000000;
      GL_9:     seg = 7'b0010000;
      GL_A:     seg = 7'b0001000;
      GL_C:     seg = 7'b1000110;
      GL_E:     seg = 7'b0000110;
      GL_F:     seg = 7'b0001110;
      GL_G:     seg = 7'b1000010;
      GL_I:     seg = 7'b1111001;
      GL_L:     seg = 7'b1000111;
      GL_N:     seg = 7'b0101011;
      GL_O:     seg = 7'b1000000;
      GL_R:     seg = 7'b0101111;
      GL_T:     seg = 7'b0000111;
      GL_U:     seg = 7'b1000001;
      GL_H:     seg = 7'b0001001;
      GL_DASH:  seg = 7'b0111111;
      GL_BLANK: seg = SEG_BLANK;
      default:  seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/param_display.sv
// Eight-digit multiplexed readout of the selected tuner parameter and its value.
// PARAM_DISPLAY_BLINK_EN: blink the value while editing; otherwise mark edit with segment g.
module param_display
  import param_display_pkg::*;
#(
  parameter int DIGIT_CYCLES = 65000,
  parameter int BLINK_CYCLES = 32_500_000
) (
  input  logic           clk_65mhz,
  input  logic           rst,
  param_display_if.slave bus
);

  localparam int DCW = $clog2(DIGIT_CYCLES);

  if (DIGIT_CYCLES < 2 || BLINK_CYCLES < 2) begin : g_bad_param
    $error("param_display: DIGIT_CYCLES and BLINK_CYCLES must be >= 2");
  end

  logic [DCW-1:0] dcnt;
  logic [2:0]     digit_idx;
  snap_t          snap;
  logic           dcnt_tc;
  logic           scan_end;
  logic           editing;
  logic           value_hidden;
  logic           force_g;
  glyph_t         val_hi;
  glyph_t         val_lo;
  glyph_t         glyph;
  logic [6:0]     seg_raw;
  logic [6:0]     cat_next;
  logic [7:0]     an_q;
  logic [6:0]     cat_q;

  assign dcnt_tc  = (dcnt == DCW'(DIGIT_CYCLES - 1));
  assign scan_end = dcnt_tc && (digit_idx == 3'd7);
  assign editing  = is_edit_state(snap.button_state);

  // Inputs are captured only at the end of a full scan so a frame never tears.
  always_ff @(posedge clk_65mhz) begin
    if (rst) begin
      dcnt      <= '0;
      digit_idx <= '0;
      snap      <= '0;
    end else begin
      if (dcnt_tc) begin
        dcnt      <= '0;
        digit_idx <= digit_idx + 3'd1;
      end else begin
        dcnt <= dcnt + DCW'(1);
      end
      if (scan_end) begin
        snap.selector_val <= bus.selector_val;
        snap.button_state <= bus.button_state;
        snap.mag_scale    <= bus.mag_scale;
        snap.live         <= bus.live;
        snap.color        <= bus.color;
        snap.scale_color  <= bus.scale_color;
        snap.scale_choice <= bus.scale_choice;
      end
    end
  end

`ifdef PARAM_DISPLAY_BLINK_EN
  localparam int BCW = $clog2(BLINK_CYCLES);

  logic [BCW-1:0] bcnt;
  logic           blink_on;

  // Held in the lit phase outside edit, so entering edit shows a full lit half-period.
  always_ff @(posedge clk_65mhz) begin
    if (rst || !editing) begin
      bcnt     <= '0;
      blink_on <= 1'b1;
    end else if (bcnt == BCW'(BLINK_CYCLES - 1)) begin
      bcnt     <= '0;
      blink_on <= !blink_on;
    end else begin
      bcnt <= bcnt + BCW'(1);
    end
  end

  assign value_hidden = editing && !blink_on;
  assign force_g      = 1'b0;
`else
  assign value_hidden = 1'b0;
  assign force_g      = editing;
`endif

  function automatic glyph_t mnemonic_glyph(input logic [2:0] sel, input logic [1:0] pos);
    glyph_t g [3:0];
    case (sel)
      SEL_GAIN:        g = '{GL_G, GL_A, GL_I, GL_N};
      SEL_LIVE:        g = '{GL_L, GL_I, GL_U, GL_E};
      SEL_COLOR:       g = '{GL_C, GL_O, GL_L, GL_R};
      SEL_COLOR_SCALE: g = '{GL_H, GL_U, GL_E, GL_BLANK};
      SEL_MUSIC_SCALE: g = '{GL_T, GL_O, GL_N, GL_E};
      default:         g = '{GL_DASH, GL_DASH, GL_DASH, GL_DASH};
    endcase
    return g[pos];
  endfunction

  always_comb begin
    val_hi = GL_BLANK;
    val_lo = GL_BLANK;
    case (snap.selector_val)
      SEL_GAIN:  val_lo = digit_glyph({2'b00, snap.mag_scale});
      SEL_LIVE: begin
        val_hi = GL_O;
        val_lo = snap.live ? GL_N : GL_F;
      end
      SEL_COLOR: val_lo = digit_glyph({3'b000, snap.color});
      SEL_COLOR_SCALE:
        val_lo = (snap.scale_color <= 3'd4) ? digit_glyph({1'b0, snap.scale_color}) : GL_DASH;
      SEL_MUSIC_SCALE:
        val_lo = (snap.scale_choice != 2'd3) ? digit_glyph({2'b00, snap.scale_choice}) : GL_DASH;
      default: ;
    endcase
    if (value_hidden) begin
      val_hi = GL_BLANK;
      val_lo = GL_BLANK;
    end
  end

  // Digits 7..4 carry the mnemonic, 3..2 stay dark, 1..0 carry the value.
  always_comb begin
    glyph = GL_BLANK;
    if (digit_idx[2]) begin
      glyph = mnemonic_glyph(snap.selector_val, digit_idx[1:0]);
    end else if (digit_idx == 3'd1) begin
      glyph = val_hi;
    end else if (digit_idx == 3'd0) begin
      glyph = val_lo;
    end
  end

  param_display_seg_glyph u_seg_glyph (
    .glyph (glyph),
    .seg   (seg_raw)
  );

  assign cat_next = (force_g && digit_idx[2] && (seg_raw != SEG_BLANK)) ?
                    (seg_raw & 7'b0111111) : seg_raw;

  always_ff @(posedge clk_65mhz) begin
    if (rst) begin
      an_q  <= 8'hFF;
      cat_q <= SEG_BLANK;
    end else begin
      an_q  <= ~(8'b0000_0001 << digit_idx);
      cat_q <= cat_next;
    end
  end

  assign bus.an_out  = an_q;
  assign bus.cat_out = cat_q;

endmodule

// File: doc/param_display.md
# param_display

Eight-digit seven-segment readout of the live tuner settings. It sits beside the parameter selector and consumes that block's outputs. It shows a 4-glyph mnemonic of the selected parameter and that parameter's current value, and blinks the value while the selector is in its edit/scroll states. Inputs are snapshotted once per full scan, so a frame never tears.

## Interface
- `DIGIT_CYCLES`, default 65000: clock cycles each digit is lit (1 ms at 65 MHz); must be ≥ 2.
- `BLINK_CYCLES`, default 32_500_000: half-period of the edit blink, in cycles; must be ≥ 2.
- `clk_65mhz` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset.
- `selector_val` in 3: parameter currently selected (0 gain, 1 live, 2 color, 3 color scale, 4 musical scale).
- `button_state` in 4: selector FSM state code.
- `mag_scale` in 2: magnitude scale, 0–3.
- `live` in 1: full/half display mode.
- `color` in 1: color mode.
- `scale_color` in 3: color scale, 0–4.
- `scale_choice` in 2: musical scale, 0–2.
- `an_out` out 8: digit anodes, active low, one-hot; bit 7 is the leftmost digit.
- `cat_out` out 7: segments {g,f,e,d,c,b,a}, active low.

## Operation
- **Digit counter** `dcnt`:
  - counts 0..DIGIT_CYCLES-1.
  - On wrap, `digit_idx` increments 0→1→…→7→0.
- **Snapshot**: all seven data inputs are registered into `snap` on the edge where `dcnt == DIGIT_CYCLES-1` and `digit_idx == 7`. A new scan always starts with a fresh snapshot.
- **Edit detect**: `editing = snap.button_state ∈ {4'b0111 NEXT_FUNCTION, 4'b1001 SCROLL_PRESSED, 4'b1010 SCROLL_FUNCTION}`.
- **Blink**:
  - While not editing: `bcnt` is held at 0 and `blink_on` = 1.
  - While editing: `bcnt` counts 0..BLINK_CYCLES-1 and `blink_on` toggles on each wrap.
  - Entering edit therefore shows the value for one full half-period first.
- **Digits 7–4, mnemonic**:
  - sel 0 "GAIn"; sel 1 "LIUE"; sel 2 "COLr"; sel 3 "HUE " (trailing blank); sel 4 "tonE".
  - sel 5–7: "----".
- **Digits 3–2**: always blank (all segments off, anode still driven).
- **Digits 1–0, value**:
  - sel 0: " n" with n = mag_scale.
  - sel 1: "On" if live, else "OF".
  - sel 2: " n" with n = color.
  - sel 3: " n" with n = scale_color; 5–7 shows " -".
  - sel 4: " n" with n = scale_choice; 3 shows " -".
  - sel 5–7: blank.
  - When `editing && !blink_on`, both value digits are blank.
- **Glyph examples**: '0' = 7'b1000000, 'L' = 7'b1000111, '-' = 7'b0111111, blank = 7'b1111111.

## Timing
- **Reset values**: an_out = 8'hFF, cat_out = 7'h7F, dcnt = 0, digit_idx = 0, bcnt = 0, blink_on = 1.
- **Snapshot reset**: all fields 0, giving the display "GAIn   0" after reset.
- **Registered outputs**: an_out and cat_out are registered decodes of (digit_idx, snap, blink_on). Both lag digit_idx by exactly 1 cycle and always change on the same edge.
- **First lit digit**: the first edge with rst low drives an_out = 8'hFE with digit 0's glyph.
- **Input latency**: an input change is visible no later than 8·DIGIT_CYCLES + 1 cycles after it occurs. A mid-scan change never appears in the current scan.
- **Reset mid-scan**: outputs are dark on the next edge and the scan restarts from digit 0.
- **Edit exit**: blink_on returns to 1 on the edge after the snapshot shows a non-edit state.

## Configuration
- **`PARAM_DISPLAY_BLINK_EN` defined**: blink behaves as above.
- **`PARAM_DISPLAY_BLINK_EN` undefined**:
  - bcnt and blink_on are not built; value digits are never blanked.
  - Editing is instead indicated by lighting all mnemonic digits with dp-equivalent segment g forced on. Blank glyphs stay blank.

## Structure
- **`param_display_pkg`**:
  - selector value constants.
  - button_state codes, shared with the selector.
  - 5-bit glyph enum (digits 0–9, letters A C E F G I L n O r t U H, dash, blank).
  - function `is_edit_state()`.
- **`seg_glyph`**: one combinational sub-module mapping glyph enum → 7-bit active-low segments.

## Test plan
- **Reset**: assert rst for 3 cycles, DIGIT_CYCLES = 4 → an_out = FF and cat_out = 7F during rst. After release, an_out steps FE, FD, …, 7F every 4 cycles; digit 7 shows 'G' (7'b1000010) and digit 0 shows '0'.
- **Live mode**: selector_val = 1, live = 1 held over two scans → second scan shows digits 7–4 "LIUE" and digits 1–0 "On".
- **Blink**: button_state = 4'b0111, BLINK_CYCLES = 10 → after the snapshot, value digits are lit 10 cycles then blank 10 cycles, alternating. Mnemonic digits never blank.
- **Mid-scan change and out-of-range**: change selector_val to 6 while digit_idx = 3 → the rest of that scan is unchanged; the next scan shows "----" and a blank value. scale_choice = 3 with sel 4 shows " -".
- **Reset mid-scan**: rst pulsed while digit_idx = 5 → outputs FF/7F the next cycle; the scan then resumes at digit 0 with the reset snapshot.
